// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared stage-register records, FSM states and memory base address
package mem_stage_pkg;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] st_value;
  } m_reg_t;
  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r_en;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
  } wb_reg_t;
endpackage

// File: rtl/mem_stage_data_mem.sv
// data_mem: word-addressed data memory, synchronous write, combinational read
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with multi-cycle data memory access and stall generation
module mem_stage import mem_stage_pkg::*; #(
  parameter int          DEPTH = 256,
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [4:0]  dest,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ST_value,
  output logic        stall,
  output logic [31:0] ALU_res_MEM,
  output logic        WB_EN_WB,
  output logic        MEM_R_EN_WB,
  output logic [4:0]  dest_WB,
  output logic [31:0] ALU_res_WB,
  output logic [31:0] mem_data_WB,
  output logic        valid_WB,
  output logic        mem_err
);
  localparam int          AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]  LAST = 4'(MEM_LATENCY - 1);
  m_reg_t        r_m;
  wb_reg_t       r_wb;
  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_err;
  logic          w_mem_op, w_done, w_bad, w_ld, w_we;
  logic [31:0]   w_off, w_rdata;
  logic [AW-1:0] w_idx;
  assign w_mem_op = r_m.valid & (r_m.mem_r_en | r_m.mem_w_en);
  assign stall    = (MEM_LATENCY > 1) && w_mem_op && (r_state == IDLE || r_cnt < LAST);
  assign w_done   = w_mem_op & ~stall;
  assign w_off    = r_m.alu_res - BASE_ADDR;
  assign w_idx    = AW'(w_off >> 2);
  assign w_bad    = (r_m.alu_res < BASE_ADDR) || ({1'b0, r_m.alu_res} >= LIMIT) || (r_m.alu_res[1:0] != 2'b00);
  assign w_ld     = r_m.mem_r_en & ~r_m.mem_w_en;
  assign w_we     = w_done & r_m.mem_w_en & ~w_bad;
  always_comb
    w_next = (r_state == IDLE) ? ((w_mem_op && MEM_LATENCY > 1) ? WAIT : IDLE)
                               : ((r_cnt == LAST) ? IDLE : WAIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == IDLE) ? 4'd0 : r_cnt + 4'd1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_m   <= '0;
      r_wb  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_done & w_bad;
      if (!stall) begin
        r_m  <= '{valid: in_valid & ~flush, wb_en: WB_EN, mem_r_en: MEM_R_EN, mem_w_en: MEM_W_EN,
                  dest: dest, alu_res: ALUResult, st_value: ST_value};
        r_wb <= '{valid: r_m.valid, wb_en: r_m.valid & r_m.wb_en & ~(r_m.mem_r_en & r_m.mem_w_en),
                  mem_r_en: r_m.valid & w_ld, dest: r_m.dest, alu_res: r_m.alu_res,
                  mem_data: (r_m.valid & w_ld & ~w_bad) ? w_rdata : 32'd0};
      end
    end
  data_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (r_m.st_value),
    .o_rdata (w_rdata)
  );
  assign ALU_res_MEM = r_m.alu_res;
  assign WB_EN_WB    = r_wb.wb_en;
  assign MEM_R_EN_WB = r_wb.mem_r_en;
  assign dest_WB     = r_wb.dest;
  assign ALU_res_WB  = r_wb.alu_res;
  assign mem_data_WB = r_wb.mem_data;
  assign valid_WB    = r_wb.valid;
  assign mem_err     = r_err;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench over three latencies of mem_stage
module tb_mem_stage;
  typedef struct {
    logic [4:0]  d;
    logic [31:0] a;
    logic [31:0] data;
    logic        wb;
    logic        rd;
    logic        err;
  } exp_t;
  logic        clk = 0, rst_n = 1;
  logic        in_valid = 0, flush = 0, WB_EN = 0, MEM_R_EN = 0, MEM_W_EN = 0;
  logic [4:0]  dest = 0;
  logic [31:0] ALUResult = 0, ST_value = 0;
  logic        a_stall [3], a_wb [3], a_rd [3], a_valid [3], a_err [3];
  logic [4:0]  a_dest [3];
  logic [31:0] a_alu_mem [3], a_alu_wb [3], a_data [3];
  logic [1:0]  sel = 2'd1;
  logic        s_stall, s_wb, s_rd, s_valid, s_err;
  logic [4:0]  s_dest;
  logic [31:0] s_alu_mem, s_alu_wb, s_data;
  int          checks = 0, fails = 0;
  exp_t        q [$];
  exp_t        e;
  bit          p_ok = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage #(.MEM_LATENCY(g == 0 ? 1 : g * 2)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .flush       (flush),
      .WB_EN       (WB_EN),
      .MEM_R_EN    (MEM_R_EN),
      .MEM_W_EN    (MEM_W_EN),
      .dest        (dest),
      .ALUResult   (ALUResult),
      .ST_value    (ST_value),
      .stall       (a_stall[g]),
      .ALU_res_MEM (a_alu_mem[g]),
      .WB_EN_WB    (a_wb[g]),
      .MEM_R_EN_WB (a_rd[g]),
      .dest_WB     (a_dest[g]),
      .ALU_res_WB  (a_alu_wb[g]),
      .mem_data_WB (a_data[g]),
      .valid_WB    (a_valid[g]),
      .mem_err     (a_err[g])
    );
  end
  assign s_stall   = a_stall[sel];
  assign s_wb      = a_wb[sel];
  assign s_rd      = a_rd[sel];
  assign s_valid   = a_valid[sel];
  assign s_err     = a_err[sel];
  assign s_dest    = a_dest[sel];
  assign s_alu_mem = a_alu_mem[sel];
  assign s_alu_wb  = a_alu_wb[sel];
  assign s_data    = a_data[sel];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lat_sel=%0d got=%0h exp=%0h", n, sel, act, exp);
    end
  endtask
  task automatic chk_zero();
    chk("rst_flags", {59'd0, s_stall, s_valid, s_wb, s_rd, s_err}, 64'd0);
    chk("rst_dest", {59'd0, s_dest}, 64'd0);
    chk("rst_alu_wb", {32'd0, s_alu_wb}, 64'd0);
    chk("rst_data", {32'd0, s_data}, 64'd0);
    chk("rst_alu_mem", {32'd0, s_alu_mem}, 64'd0);
  endtask
  task automatic issue(input logic fl, input logic fs, input logic wb, input logic r, input logic w,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] st,
                       input int es, input logic [31:0] ed, input logic ee);
    int n;
    in_valid = 1; flush = fl; WB_EN = wb; MEM_R_EN = r; MEM_W_EN = w;
    dest = d; ALUResult = a; ST_value = st;
    if (!fl) q.push_back('{d, a, ed, wb & ~(r & w), r & ~w, ee});
    @(negedge clk);
    in_valid = 0; flush = fs;
    chk("alu_res_mem", {32'd0, s_alu_mem}, {32'd0, a});
    n = 0;
    while (s_stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    flush = 0;
    chk("stall_cycles", 64'(n), 64'(es));
  endtask
  always @(negedge clk) begin
    if (p_ok && s_valid) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL wb_unexpected got alu=%0h exp=none", s_alu_wb);
      end else begin
        e = q.pop_front();
        chk("wb_dest", {59'd0, s_dest}, {59'd0, e.d});
        chk("wb_alu", {32'd0, s_alu_wb}, {32'd0, e.a});
        chk("wb_data", {32'd0, s_data}, {32'd0, e.data});
        chk("wb_en", {63'd0, s_wb}, {63'd0, e.wb});
        chk("wb_rd", {63'd0, s_rd}, {63'd0, e.rd});
        chk("mem_err", {63'd0, s_err}, {63'd0, e.err});
      end
    end
    p_ok = rst_n && !s_stall;
  end
  initial begin
    #1 rst_n = 0;
    #2 chk_zero();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(0, 0, 1, 0, 0, 5'd5, 32'd7, 32'd0, 0, 32'd0, 0);
    issue(0, 0, 0, 0, 1, 5'd0, 32'd1028, 32'hDEADBEEF, 1, 32'd0, 0);
    issue(0, 0, 1, 1, 0, 5'd3, 32'd1028, 32'd0, 1, 32'hDEADBEEF, 0);
    issue(0, 0, 1, 1, 0, 5'd4, 32'd2048, 32'd0, 1, 32'd0, 1);
    issue(0, 0, 1, 1, 0, 5'd4, 32'd1030, 32'd0, 1, 32'd0, 1);
    issue(0, 0, 1, 1, 0, 5'd4, 32'd1020, 32'd0, 1, 32'd0, 1);
    issue(0, 0, 0, 0, 1, 5'd0, 32'd1024, 32'hA5A5A5A5, 1, 32'd0, 0);
    issue(0, 0, 0, 0, 1, 5'd0, 32'd1030, 32'h12345678, 1, 32'd0, 1);
    issue(0, 0, 0, 0, 1, 5'd0, 32'd2048, 32'h0BADF00D, 1, 32'd0, 1);
    issue(0, 0, 1, 1, 0, 5'd6, 32'd1028, 32'd0, 1, 32'hDEADBEEF, 0);
    issue(0, 0, 1, 1, 0, 5'd7, 32'd1024, 32'd0, 1, 32'hA5A5A5A5, 0);
    issue(0, 0, 1, 1, 1, 5'd8, 32'd1036, 32'hCAFEF00D, 1, 32'd0, 0);
    issue(1, 0, 1, 1, 0, 5'd9, 32'd1036, 32'd0, 0, 32'd0, 0);
    issue(0, 0, 1, 1, 0, 5'd9, 32'd1036, 32'd0, 1, 32'hCAFEF00D, 0);
    issue(0, 0, 1, 0, 0, 5'd10, 32'hFFFFFFFC, 32'd0, 0, 32'd0, 0);
    repeat (10) @(negedge clk);
    sel = 2'd2;
    issue(0, 1, 0, 0, 1, 5'd0, 32'd1040, 32'h77, 3, 32'd0, 0);
    issue(0, 0, 1, 1, 0, 5'd2, 32'd1040, 32'd0, 3, 32'h77, 0);
    issue(0, 0, 0, 0, 1, 5'd0, 32'd1024, 32'h1111, 3, 32'd0, 0);
    in_valid = 1; WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 1; dest = 0; ALUResult = 32'd1024; ST_value = 32'h2222;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk_zero();
    @(negedge clk);
    rst_n = 1;
    issue(0, 0, 1, 1, 0, 5'd1, 32'd1024, 32'd0, 3, 32'h1111, 0);
    repeat (10) @(negedge clk);
    sel = 2'd0;
    issue(0, 0, 0, 0, 1, 5'd0, 32'd1032, 32'h5, 0, 32'd0, 0);
    issue(0, 0, 1, 1, 0, 5'd2, 32'd1032, 32'd0, 0, 32'h5, 0);
    issue(0, 0, 1, 1, 0, 5'd3, 32'd2048, 32'd0, 0, 32'd0, 1);
    issue(0, 0, 1, 0, 0, 5'd4, 32'd99, 32'd0, 0, 32'd0, 0);
    repeat (10) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: DEPTH, 256, data-memory words; MEM_LATENCY, 2, cycles per load/store (legal 1..8); BASE_ADDR, 32'd1024, byte address of word 0.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; rst_n in 1 reset; in_valid in 1 EXE result valid; flush in 1 insert bubble; WB_EN in 1 writeback enable; MEM_R_EN in 1 load; MEM_W_EN in 1 store; dest in 5 destination register; ALUResult in 32 ALU result/byte address; ST_value in 32 store data; stall out 1 freeze upstream stages; ALU_res_MEM out 32 forwarding value; WB_EN_WB out 1; MEM_R_EN_WB out 1; dest_WB out 5; ALU_res_WB out 32; mem_data_WB out 32 load data; valid_WB out 1; mem_err out 1 bad-access pulse.
REQ-003 The block SHALL use one clock, clk (rising edge); reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL hold an M-register (valid, WB_EN, MEM_R_EN, MEM_W_EN, dest, ALUResult, ST_value) loaded on a clk edge when stall=0, with valid=in_valid&~flush.
REQ-005 ALU_res_MEM SHALL equal the M-register ALUResult at all times (combinational from the register, no added latency).
REQ-006 A valid non-memory op SHALL occupy M for 1 cycle, then load the WB-register (WB_EN_WB, MEM_R_EN_WB=0, dest_WB, ALU_res_WB, valid_WB=1, mem_data_WB=0) with no stall.
REQ-007 A valid memory op SHALL occupy M for exactly MEM_LATENCY cycles; stall SHALL be 1 during the first MEM_LATENCY-1 of those cycles and 0 in the last.
REQ-008 FSM states SHALL be IDLE and WAIT: IDLE->WAIT when M holds a valid memory op and MEM_LATENCY>1; WAIT increments cnt; WAIT->IDLE at the edge where cnt==MEM_LATENCY-1; cnt clears on entry to IDLE.
REQ-009 stall SHALL be combinational: 1 in IDLE with a valid memory op in M and MEM_LATENCY>1, 1 in WAIT while cnt<MEM_LATENCY-1, else 0.
REQ-010 On the completion edge a store SHALL write ST_value to word (ALUResult-BASE_ADDR)>>2; a load SHALL capture that word into mem_data_WB; the WB-register SHALL be loaded on the same edge.
REQ-011 With MEM_LATENCY=1 memory ops SHALL behave as REQ-006 timing (no stall) but with the access performed.
REQ-012 An address below BASE_ADDR, at or above BASE_ADDR+4*DEPTH, or with ALUResult[1:0]!=0 SHALL suppress the write, return mem_data_WB=0, and pulse mem_err for exactly the completion cycle's following cycle (registered, 1 cycle).
REQ-013 MEM_R_EN=MEM_W_EN=1 SHALL be treated as a store only, with WB_EN_WB forced to 0.
REQ-014 flush while stall=1 SHALL be ignored; the in-flight op SHALL complete.
REQ-015 An invalid M entry SHALL load the WB-register with valid_WB=0 and WB_EN_WB=0.
REQ-016 A load to the address of a store completing one cycle earlier SHALL return the stored data.

Reset
REQ-017 rst_n=0 SHALL immediately clear: M valid, all WB-register outputs, mem_err, cnt, state=IDLE; stall SHALL therefore read 0.
REQ-018 Reset mid-access SHALL abort the op with no write; memory contents SHALL NOT be reset.

Structure
REQ-019 The package SHALL hold the FSM state enum, BASE_ADDR default and the M/WB register record typedefs, shared with the EXE and WB stages.
REQ-020 The data memory SHALL be a sub-module data_mem (DEPTH words, synchronous write, combinational read).

Verification
REQ-021 Store 32'hDEADBEEF to 1028, MEM_LATENCY=2 -> stall high 1 cycle, then load 1028 -> mem_data_WB=32'hDEADBEEF, MEM_R_EN_WB=1.
REQ-022 ADD result 32'd7, dest=5, WB_EN=1 -> next cycle ALU_res_MEM=7, following cycle ALU_res_WB=7, dest_WB=5, stall never 1.
REQ-023 Load from 2048 (DEPTH=256) and from 1030 -> mem_err pulses 1 cycle each, mem_data_WB=0, no memory change.
REQ-024 MEM_LATENCY=4, store then flush asserted during stall -> stall high 3 cycles, store completes, flush ignored.
REQ-025 rst_n low in cycle 2 of a 4-cycle store to 1024 -> all outputs 0 at once, later load 1024 returns pre-store value.
REQ-026 MEM_LATENCY=1, back-to-back store 1032 = 32'h5 then load 1032 -> no stall, load returns 32'h5.
